// File: rtl/echo_pkg.sv
// Shared widths, saturation bounds and FSM encoding for the echo mixer.
// ECHO_MIX_SAT_EN selects saturating rather than wrapping output arithmetic.
package echo_pkg;

  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 8;
  localparam int DELAY_W  = 13;
  localparam int SUM_W    = 18;

  localparam logic signed [SUM_W-1:0] SAT_MAX = 18'sd32767;
  localparam logic signed [SUM_W-1:0] SAT_MIN = -18'sd32768;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RAMP   = 2'd1,
    STEADY = 2'd2
  } mix_state_t;

endpackage

// File: rtl/echo_mixer_gain_ramp.sv
// Warmup counter, delay tracking and gain ramp FSM of the echo mixer.
// It produces the gain and the wet-path enable used for each sample.
module gain_ramp #(
  parameter int GAIN_W  = echo_pkg::GAIN_W,
  parameter int DELAY_W = echo_pkg::DELAY_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sample_valid,
  input  logic [DELAY_W-1:0] delay_num,
  input  logic [GAIN_W-1:0]  gain_tgt,
  output logic [GAIN_W-1:0]  gain_cur,
  output logic               wet_active
);
  import echo_pkg::*;

  localparam logic [GAIN_W-1:0]  GAIN_ONE  = {{(GAIN_W-1){1'b0}}, 1'b1};
  localparam logic [DELAY_W-1:0] DELAY_ONE = {{(DELAY_W-1){1'b0}}, 1'b1};

  mix_state_t         state_r, state_s;
  logic [DELAY_W-1:0] wcnt_r, wcnt_s;
  logic [DELAY_W-1:0] delay_q_r, delay_q_s;
  logic [GAIN_W-1:0]  gain_r, gain_s, step_s;
  logic               wet_r, wet_s;

  // One LSB toward the target gain
  always_comb begin
    step_s = gain_r;
    if (gain_r < gain_tgt) begin
      step_s = gain_r + GAIN_ONE;
    end else if (gain_r > gain_tgt) begin
      step_s = gain_r - GAIN_ONE;
    end else begin
      step_s = gain_r;
    end
  end

  // A delay change outranks any sample step in the same cycle
  always_comb begin
    state_s   = state_r;
    wcnt_s    = wcnt_r;
    delay_q_s = delay_q_r;
    gain_s    = gain_r;
    wet_s     = wet_r;
    if (delay_num != delay_q_r) begin
      delay_q_s = delay_num;
      wcnt_s    = {DELAY_W{1'b0}};
      gain_s    = {GAIN_W{1'b0}};
      wet_s     = 1'b0;
      state_s   = WARMUP;
    end else begin
      case (state_r)
        WARMUP: begin
          if (sample_valid && (wcnt_r == delay_q_r)) begin
            wet_s   = 1'b1;
            gain_s  = step_s;
            state_s = RAMP;
          end else if (sample_valid) begin
            wcnt_s = wcnt_r + DELAY_ONE;
          end else begin
            wcnt_s = wcnt_r;
          end
        end
        RAMP: begin
          if (gain_r == gain_tgt) begin
            state_s = STEADY;
          end else if (sample_valid) begin
            gain_s  = step_s;
            state_s = (step_s == gain_tgt) ? STEADY : RAMP;
          end else begin
            state_s = RAMP;
          end
        end
        STEADY: begin
          if (gain_tgt != gain_r) begin
            state_s = RAMP;
          end else begin
            state_s = STEADY;
          end
        end
        default: begin
          state_s = WARMUP;
          wcnt_s  = {DELAY_W{1'b0}};
          gain_s  = {GAIN_W{1'b0}};
          wet_s   = 1'b0;
        end
      endcase
    end
  end

  // FSM and ramp state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= WARMUP;
      wcnt_r    <= {DELAY_W{1'b0}};
      delay_q_r <= {DELAY_W{1'b0}};
      gain_r    <= {GAIN_W{1'b0}};
      wet_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      wcnt_r    <= wcnt_s;
      delay_q_r <= delay_q_s;
      gain_r    <= gain_s;
      wet_r     <= wet_s;
    end
  end

  assign gain_cur   = gain_r;
  assign wet_active = wet_r;

endmodule

// File: rtl/echo_mixer.sv
// Echo output mixer: out = dry + floor(wet*gain/256), two-stage pipeline.
// Define ECHO_MIX_SAT_EN to saturate the sum; otherwise it wraps to 16 bits.
module echo_mixer #(
  parameter int SAMPLE_W = echo_pkg::SAMPLE_W,
  parameter int GAIN_W   = echo_pkg::GAIN_W,
  parameter int DELAY_W  = echo_pkg::DELAY_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] dry_in,
  input  logic [SAMPLE_W-1:0] wet_in,
  input  logic [DELAY_W-1:0]  delay_num,
  input  logic [GAIN_W-1:0]   gain_tgt,
  output logic [SAMPLE_W-1:0] out,
  output logic                out_valid,
  output logic                wet_active
);
  import echo_pkg::*;

  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam int MIX_W  = SAMPLE_W + 2;

  logic [GAIN_W-1:0]          gain_cur_s;
  logic                       wet_active_s;
  logic [GAIN_W-1:0]          gain_eff_s;
  logic signed [PROD_W-1:0]   wet_x_s, gain_x_s, prod_s, prod_r;
  logic signed [SAMPLE_W-1:0] dry_r;
  logic                       v1_r;
  logic signed [MIX_W-1:0]    scaled_s, sum_s;
  logic signed [SAMPLE_W-1:0] mix_s;
  logic [SAMPLE_W-1:0]        out_r;
  logic                       out_valid_r;
  logic                       unused_bits_s;

  gain_ramp #(
    .GAIN_W  (GAIN_W),
    .DELAY_W (DELAY_W)
  ) u_gain_ramp (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .delay_num    (delay_num),
    .gain_tgt     (gain_tgt),
    .gain_cur     (gain_cur_s),
    .wet_active   (wet_active_s)
  );

  // Gain is always zero in warmup, but the mute keeps the wet path explicit
  assign gain_eff_s = wet_active_s ? gain_cur_s : {GAIN_W{1'b0}};
  assign wet_x_s    = {{(PROD_W-SAMPLE_W){wet_in[SAMPLE_W-1]}}, wet_in};
  assign gain_x_s   = {{(PROD_W-GAIN_W){1'b0}}, gain_eff_s};
  assign prod_s     = wet_x_s * gain_x_s;

  assign scaled_s = {prod_r[PROD_W-1], prod_r[PROD_W-1:GAIN_W]};
  assign sum_s    = {{2{dry_r[SAMPLE_W-1]}}, dry_r} + scaled_s;

`ifdef ECHO_MIX_SAT_EN
  // Clamp the 18-bit sum into the sample range
  always_comb begin
    mix_s = sum_s[SAMPLE_W-1:0];
    if (sum_s > SAT_MAX) begin
      mix_s = SAT_MAX[SAMPLE_W-1:0];
    end else if (sum_s < SAT_MIN) begin
      mix_s = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      mix_s = sum_s[SAMPLE_W-1:0];
    end
  end
  assign unused_bits_s = ^prod_r[GAIN_W-1:0];
`else
  assign mix_s         = sum_s[SAMPLE_W-1:0];
  assign unused_bits_s = ^{prod_r[GAIN_W-1:0], sum_s[MIX_W-1:SAMPLE_W]};
`endif

  // Stage 1: product and aligned dry sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_r <= {PROD_W{1'b0}};
      dry_r  <= {SAMPLE_W{1'b0}};
      v1_r   <= 1'b0;
    end else begin
      v1_r <= sample_valid;
      if (sample_valid) begin
        prod_r <= prod_s;
        dry_r  <= dry_in;
      end
    end
  end

  // Stage 2: mixed output, held between strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_r       <= {SAMPLE_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= v1_r;
      if (v1_r) begin
        out_r <= mix_s;
      end
    end
  end

  assign out        = out_r;
  assign out_valid  = out_valid_r;
  assign wet_active = wet_active_s;

endmodule

// File: tb/tb_echo_mixer.sv
// Self-checking bench for echo_mixer: directed sequences, a constant vector
// table and randomized traffic scored against a sample-level reference model.
module tb_echo_mixer;
  import echo_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] dry_in = 16'd0;
  logic [15:0] wet_in = 16'd0;
  logic [12:0] delay_num = 13'd0;
  logic [7:0]  gain_tgt = 8'd0;
  logic [15:0] out;
  logic        out_valid;
  logic        wet_active;

  always #5 clk = ~clk;

  echo_mixer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .dry_in       (dry_in),
    .wet_in       (wet_in),
    .delay_num    (delay_num),
    .gain_tgt     (gain_tgt),
    .out          (out),
    .out_valid    (out_valid),
    .wet_active   (wet_active)
  );

`ifdef ECHO_MIX_SAT_EN
  localparam int EXP_POS = 32767;
  localparam int EXP_NEG = -32768;
`else
  localparam int EXP_POS = -897;
  localparam int EXP_NEG = 128;
`endif

  typedef struct {int due; int val;} exp_t;
  typedef struct {int dry; int wet; int exp_out;} vec_t;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   obs_q[$];
  int   last_out = 0;
  // reference model state (sample-level view of the spec)
  int   m_delay = 0;
  int   m_wcnt = 0;
  int   m_gain = 0;
  bit   m_wet = 1'b0;
  bit   m_settled = 1'b0;
  vec_t vecs[7];

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int mix_ref(int dry, int wet, int g);
    int p;
    int sc;
    int s;
    p  = wet * g;
    sc = (p >= 0) ? p / 256 : -((-p + 255) / 256);
    s  = dry + sc;
`ifdef ECHO_MIX_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`else
    s = ((s % 65536) + 65536) % 65536;
    if (s > 32767) s = s - 65536;
`endif
    return s;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic model_loop();
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        exp_q.delete();
        m_delay = 0; m_wcnt = 0; m_gain = 0; m_wet = 1'b0; m_settled = 1'b0;
      end else begin
        int t;
        cyc++;
        t = int'(gain_tgt);
        if (sample_valid)
          exp_q.push_back('{cyc + 1, mix_ref(int'($signed(dry_in)), int'($signed(wet_in)),
                                             m_wet ? m_gain : 0)});
        if (int'(delay_num) != m_delay) begin
          m_delay = int'(delay_num);
          m_wcnt = 0; m_gain = 0; m_wet = 1'b0; m_settled = 1'b0;
        end else if (!m_wet) begin
          if (sample_valid) begin
            if (m_wcnt == m_delay) begin
              m_wet = 1'b1;
              if (t > m_gain) m_gain++;
              else if (t < m_gain) m_gain--;
            end else begin
              m_wcnt++;
            end
          end
        end else if (m_settled) begin
          if (t != m_gain) m_settled = 1'b0;
        end else if (m_gain == t) begin
          m_settled = 1'b1;
        end else if (sample_valid) begin
          m_gain = (t > m_gain) ? m_gain + 1 : m_gain - 1;
          m_settled = (m_gain == t);
        end
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (out_valid) obs_q.push_back(int'($signed(out)));
      if (!reset_n) begin
        last_out = 0;
        exp_q.delete();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out", int'($signed(out)), 0);
        check("rst_wet_active", int'(wet_active), 0);
      end else begin
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          check("missed_out_valid", 0, 1);
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          check("out_valid", int'(out_valid), 1);
          check("out", int'($signed(out)), exp_q[0].val);
          last_out = exp_q[0].val;
          void'(exp_q.pop_front());
        end else begin
          check("out_valid_idle", int'(out_valid), 0);
          check("out_hold", int'($signed(out)), last_out);
        end
        check("wet_active", int'(wet_active), int'(m_wet));
        check("gain_cur", int'(dut.gain_cur_s), m_gain);
        check("state_warmup", int'(dut.u_gain_ramp.state_r == WARMUP), int'(!m_wet));
        check("state_steady", int'(dut.u_gain_ramp.state_r == STEADY), int'(m_settled));
      end
    end
  endtask

  task automatic send(input int d, input int w);
    dry_in = d[15:0];
    wet_in = w[15:0];
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{32000, 32767, EXP_POS};
    vecs[1] = '{-32768, -32768, EXP_NEG};
    vecs[2] = '{100, 256, 355};
    vecs[3] = '{0, -1, -1};
    vecs[4] = '{-5, 1, -5};
    vecs[5] = '{32767, 0, 32767};
    vecs[6] = '{-100, -32768, -32740};

    fork
      model_loop();
      monitor();
    join_none

    idle(3);
    reset_n = 1'b1;
    idle(2);

    // zero delay from reset: first strobe is already wet and ramps
    gain_tgt = 8'd16;
    idle(1);
    send(100, 2000);
    check("zero_delay_wet", int'(wet_active), 1);
    check("zero_delay_ramp", int'(dut.gain_cur_s), 1);
    for (int i = 0; i < 20; i++) send(rnd16(), rnd16());

    // warmup of 4 then ramp to 128 with constant wet=1000
    delay_num = 13'd4;
    gain_tgt = 8'd128;
    idle(2);
    obs_q.delete();
    for (int i = 1; i <= 140; i++) begin
      send(0, 1000);
      if (i == 4) check("wet_before_s5", int'(wet_active), 0);
      if (i == 5) check("wet_rise_s5", int'(wet_active), 1);
      if (i == 131) check("not_steady_127", int'(dut.u_gain_ramp.state_r == STEADY), 0);
      if (i == 132) check("steady_128", int'(dut.u_gain_ramp.state_r == STEADY), 1);
    end
    idle(3);
    check("ramp_obs_count", obs_q.size(), 140);
    if (obs_q.size() >= 140) begin
      for (int i = 0; i < 5; i++) check("warmup_zero", obs_q[i], 0);
      check("ramp_s6", obs_q[5], 3);
      check("ramp_s7", obs_q[6], 7);
      check("ramp_s132", obs_q[131], 496);
      check("ramp_s133", obs_q[132], 500);
    end
    check("ramp_gain_128", int'(dut.gain_cur_s), 128);

    // retarget 128 -> 120 with strobes on every cycle
    gain_tgt = 8'd120;
    idle(1);
    for (int i = 1; i <= 8; i++) begin
      send(rnd16(), rnd16());
      if (i == 7) check("retarget_ramping", int'(dut.u_gain_ramp.state_r == STEADY), 0);
    end
    check("retarget_steady", int'(dut.u_gain_ramp.state_r == STEADY), 1);
    check("retarget_gain", int'(dut.gain_cur_s), 120);

    // settle at full gain, then apply constant vectors
    gain_tgt = 8'd255;
    idle(1);
    for (int i = 0; i < 400 && !m_settled; i++) send(rnd16(), rnd16());
    check("sat_gain_255", int'(dut.gain_cur_s), 255);
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].dry, vecs[i].wet);
      idle(1);
      check($sformatf("vec%0d", i), int'($signed(out)), vecs[i].exp_out);
    end

    // delay change 4 -> 2 while steady
    delay_num = 13'd2;
    idle(1);
    check("dchg_wet_fall", int'(wet_active), 0);
    check("dchg_gain_zero", int'(dut.gain_cur_s), 0);
    for (int i = 0; i < 3; i++) begin
      int d;
      d = rnd16();
      send(d, rnd16());
      idle(1);
      check("dchg_dry_only", int'($signed(out)), d);
    end
    check("dchg_wet_rise", int'(wet_active), 1);
    send(0, 25600);
    idle(1);
    check("dchg_ramp_out", int'($signed(out)), 100);
    check("dchg_ramp_gain", int'(dut.gain_cur_s), 2);

    // asynchronous reset with samples in flight
    send(1234, 0);
    send(-1234, 0);
    dry_in = 16'd77;
    sample_valid = 1'b1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out", int'($signed(out)), 0);
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_wet", int'(wet_active), 0);
    @(negedge clk);
    sample_valid = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(3);
    send(555, 0);
    check("post_rst_lat1", int'(out_valid), 0);
    idle(1);
    check("post_rst_lat2", int'(out_valid), 1);
    check("post_rst_out", int'($signed(out)), 555);

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      sample_valid = ($urandom_range(0, 3) != 0);
      dry_in = 16'($urandom_range(0, 65535));
      wet_in = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 199) == 0) delay_num = 13'($urandom_range(0, 5));
      if ($urandom_range(0, 149) == 0) gain_tgt = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    sample_valid = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
